// File: rtl/tlul_pkg.sv
// Shared TL-UL opcode constants and arbiter state type for the channel-A arbiter.
package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'd0;
  localparam logic [2:0] PutPartialData = 3'd1;
  localparam logic [2:0] Get            = 3'd4;
  localparam logic [2:0] AccessAck      = 3'd0;
  localparam logic [2:0] AccessAckData  = 3'd1;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_ERR
  } arb_state_e;

  // D-channel opcode that answers a given A-channel opcode.
  function automatic logic [2:0] resp_opcode(input logic [2:0] a_opcode);
    return (a_opcode == Get) ? AccessAckData : AccessAck;
  endfunction

endpackage

// File: rtl/tlul_rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after rr_ptr, wrapping.
module tlul_rr_arbiter #(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned IDX_WIDTH   = 2
) (
  input  logic [NUM_MASTERS-1:0] eligible,
  input  logic [IDX_WIDTH-1:0]   rr_ptr,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDX_WIDTH-1:0]   grant_idx,
  output logic                   grant_valid
);

  int unsigned idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_MASTERS) begin
        idx = idx - NUM_MASTERS;
      end
      for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
        if (!grant_valid && (j == idx) && eligible[j]) begin
          grant[j]    = 1'b1;
          grant_idx   = IDX_WIDTH'(j);
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tlul_a_arbiter.sv
// N:1 TL-UL channel-A arbiter with source tagging, D routing and per-master outstanding limits.
// Optional local decode-error responder enabled by defining TLUL_ARB_DECERR_EN.
module tlul_a_arbiter
  import tlul_pkg::*;
#(
  parameter int unsigned NUM_MASTERS  = 3,
  parameter int unsigned MIDX_WIDTH   = 2,
  parameter int unsigned SRC_WIDTH    = 2,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MASK_WIDTH   = 4,
  parameter int unsigned SIZE_WIDTH   = 3,
  parameter int unsigned OPCODE_WIDTH = 3,
  parameter int unsigned PARAM_WIDTH  = 3,
  parameter int unsigned SINK_WIDTH   = 1,
  parameter int unsigned MAX_OUTST    = 4,
  parameter logic [ADDR_WIDTH-1:0] SLAVE_BASE = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] SLAVE_MASK = 32'hFFFF_F000
) (
  input  logic                                clk_100,
  input  logic                                reset,
  input  logic [NUM_MASTERS-1:0]              master_a_valid,
  output logic [NUM_MASTERS-1:0]              master_a_ready,
  input  logic [NUM_MASTERS*OPCODE_WIDTH-1:0] master_a_opcode,
  input  logic [NUM_MASTERS*PARAM_WIDTH-1:0]  master_a_param,
  input  logic [NUM_MASTERS*SIZE_WIDTH-1:0]   master_a_size,
  input  logic [NUM_MASTERS*SRC_WIDTH-1:0]    master_a_source,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   master_a_address,
  input  logic [NUM_MASTERS*MASK_WIDTH-1:0]   master_a_mask,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   master_a_data,
  output logic [NUM_MASTERS-1:0]              master_d_valid,
  input  logic [NUM_MASTERS-1:0]              master_d_ready,
  output logic [NUM_MASTERS*OPCODE_WIDTH-1:0] master_d_opcode,
  output logic [NUM_MASTERS*PARAM_WIDTH-1:0]  master_d_param,
  output logic [NUM_MASTERS*SIZE_WIDTH-1:0]   master_d_size,
  output logic [NUM_MASTERS*SRC_WIDTH-1:0]    master_d_source,
  output logic [NUM_MASTERS*SINK_WIDTH-1:0]   master_d_sink,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0]   master_d_data,
  output logic [NUM_MASTERS-1:0]              master_d_error,
  output logic                                slave_a_valid,
  input  logic                                slave_a_ready,
  output logic [OPCODE_WIDTH-1:0]             slave_a_opcode,
  output logic [PARAM_WIDTH-1:0]              slave_a_param,
  output logic [SIZE_WIDTH-1:0]               slave_a_size,
  output logic [SRC_WIDTH+MIDX_WIDTH-1:0]     slave_a_source,
  output logic [ADDR_WIDTH-1:0]               slave_a_address,
  output logic [MASK_WIDTH-1:0]               slave_a_mask,
  output logic [DATA_WIDTH-1:0]               slave_a_data,
  input  logic                                slave_d_valid,
  output logic                                slave_d_ready,
  input  logic [OPCODE_WIDTH-1:0]             slave_d_opcode,
  input  logic [PARAM_WIDTH-1:0]              slave_d_param,
  input  logic [SIZE_WIDTH-1:0]               slave_d_size,
  input  logic [SRC_WIDTH+MIDX_WIDTH-1:0]     slave_d_source,
  input  logic [SINK_WIDTH-1:0]               slave_d_sink,
  input  logic [DATA_WIDTH-1:0]               slave_d_data,
  input  logic                                slave_d_error
);

  localparam int unsigned CntW = $clog2(MAX_OUTST + 1);
`ifdef TLUL_ARB_DECERR_EN
  localparam bit DecErrEn = 1'b1;
`else
  localparam bit DecErrEn = 1'b0;
`endif

  arb_state_e state_q, state_d;
  logic [MIDX_WIDTH-1:0] grant_idx_q, grant_idx_d;
  logic [MIDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d, rr_next;
  logic [CntW-1:0] outst_q [NUM_MASTERS];
  logic [CntW-1:0] outst_d [NUM_MASTERS];
  logic err_phase_q, err_phase_d;
  logic [OPCODE_WIDTH-1:0] err_opcode_q, err_opcode_d;
  logic [SIZE_WIDTH-1:0] err_size_q, err_size_d;
  logic [SRC_WIDTH-1:0] err_source_q, err_source_d;

  logic [NUM_MASTERS-1:0] eligible, arb_grant;
  logic [MIDX_WIDTH-1:0] arb_idx;
  logic arb_valid, cand_miss, a_hs, d_hs, d_ok, err_block, local_valid;
  logic [MIDX_WIDTH-1:0] d_idx;

  logic [OPCODE_WIDTH-1:0] sel_opcode;
  logic [PARAM_WIDTH-1:0] sel_param;
  logic [SIZE_WIDTH-1:0] sel_size;
  logic [SRC_WIDTH-1:0] sel_source;
  logic [ADDR_WIDTH-1:0] sel_address, cand_address;
  logic [MASK_WIDTH-1:0] sel_mask;
  logic [DATA_WIDTH-1:0] sel_data;
  logic sel_d_ready;

  always_comb begin
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      eligible[i] = master_a_valid[i] && (outst_q[i] < CntW'(MAX_OUTST));
    end
  end

  tlul_rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_WIDTH   (MIDX_WIDTH)
  ) u_rr_arbiter (
    .eligible    (eligible),
    .rr_ptr      (rr_ptr_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // Registered grant selects the forwarded fields; the fresh one-hot pick drives the decode.
  always_comb begin
    sel_opcode   = '0;
    sel_param    = '0;
    sel_size     = '0;
    sel_source   = '0;
    sel_address  = '0;
    sel_mask     = '0;
    sel_data     = '0;
    sel_d_ready  = 1'b0;
    cand_address = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant_idx_q == MIDX_WIDTH'(i)) begin
        sel_opcode  = master_a_opcode[i*OPCODE_WIDTH +: OPCODE_WIDTH];
        sel_param   = master_a_param[i*PARAM_WIDTH +: PARAM_WIDTH];
        sel_size    = master_a_size[i*SIZE_WIDTH +: SIZE_WIDTH];
        sel_source  = master_a_source[i*SRC_WIDTH +: SRC_WIDTH];
        sel_address = master_a_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_mask    = master_a_mask[i*MASK_WIDTH +: MASK_WIDTH];
        sel_data    = master_a_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_d_ready = master_d_ready[i];
      end
      if (arb_grant[i]) begin
        cand_address = master_a_address[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign cand_miss       = DecErrEn && ((cand_address & SLAVE_MASK) != SLAVE_BASE);
  assign rr_next         = (grant_idx_q == MIDX_WIDTH'(NUM_MASTERS - 1)) ? '0 :
                           grant_idx_q + MIDX_WIDTH'(1);
  assign slave_a_opcode  = sel_opcode;
  assign slave_a_param   = sel_param;
  assign slave_a_size    = sel_size;
  assign slave_a_source  = {grant_idx_q, sel_source};
  assign slave_a_address = sel_address;
  assign slave_a_mask    = sel_mask;
  assign slave_a_data    = sel_data;

  always_comb begin
    state_d        = state_q;
    grant_idx_d    = grant_idx_q;
    rr_ptr_d       = rr_ptr_q;
    err_phase_d    = err_phase_q;
    err_opcode_d   = err_opcode_q;
    err_size_d     = err_size_q;
    err_source_d   = err_source_q;
    master_a_ready = '0;
    slave_a_valid  = 1'b0;
    a_hs           = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (arb_valid) begin
          grant_idx_d = arb_idx;
          err_phase_d = 1'b0;
          state_d     = cand_miss ? ARB_ERR : ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        slave_a_valid = 1'b1;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
          if (grant_idx_q == MIDX_WIDTH'(i)) master_a_ready[i] = slave_a_ready;
        end
        if (slave_a_ready) begin
          a_hs     = 1'b1;
          rr_ptr_d = rr_next;
          state_d  = ARB_IDLE;
        end
      end
      ARB_ERR: begin
        if (!err_phase_q) begin
          // Swallow the beat and latch what the local error response must echo.
          for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (grant_idx_q == MIDX_WIDTH'(i)) master_a_ready[i] = 1'b1;
          end
          err_opcode_d = OPCODE_WIDTH'(resp_opcode(3'(sel_opcode)));
          err_size_d   = sel_size;
          err_source_d = sel_source;
          err_phase_d  = 1'b1;
          rr_ptr_d     = rr_next;
        end else if (sel_d_ready) begin
          err_phase_d = 1'b0;
          state_d     = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign d_idx       = slave_d_source[SRC_WIDTH +: MIDX_WIDTH];
  assign d_ok        = 32'(d_idx) < NUM_MASTERS;
  assign err_block   = (state_q == ARB_ERR);
  assign local_valid = err_block && err_phase_q && !reset;

  always_comb begin
    master_d_valid  = '0;
    master_d_opcode = {NUM_MASTERS{slave_d_opcode}};
    master_d_param  = {NUM_MASTERS{slave_d_param}};
    master_d_size   = {NUM_MASTERS{slave_d_size}};
    master_d_source = {NUM_MASTERS{slave_d_source[SRC_WIDTH-1:0]}};
    master_d_sink   = {NUM_MASTERS{slave_d_sink}};
    master_d_data   = {NUM_MASTERS{slave_d_data}};
    master_d_error  = {NUM_MASTERS{slave_d_error}};
    slave_d_ready   = 1'b0;
    if (!reset) begin
      // Responses tagged for a non-existent master are sunk.
      slave_d_ready = !d_ok;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (d_ok && (d_idx == MIDX_WIDTH'(i)) &&
            !(err_block && (grant_idx_q == MIDX_WIDTH'(i)))) begin
          master_d_valid[i] = slave_d_valid;
          slave_d_ready     = master_d_ready[i];
        end
      end
    end
    if (local_valid) begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (grant_idx_q == MIDX_WIDTH'(i)) begin
          master_d_valid[i]                              = 1'b1;
          master_d_opcode[i*OPCODE_WIDTH +: OPCODE_WIDTH] = err_opcode_q;
          master_d_param[i*PARAM_WIDTH +: PARAM_WIDTH]    = '0;
          master_d_size[i*SIZE_WIDTH +: SIZE_WIDTH]       = err_size_q;
          master_d_source[i*SRC_WIDTH +: SRC_WIDTH]       = err_source_q;
          master_d_sink[i*SINK_WIDTH +: SINK_WIDTH]       = '0;
          master_d_data[i*DATA_WIDTH +: DATA_WIDTH]       = '0;
          master_d_error[i]                              = 1'b1;
        end
      end
    end
  end

  assign d_hs = slave_d_valid && slave_d_ready && d_ok;

  // Simultaneous accept and response on one master cancel; decrement saturates at zero.
  always_comb begin
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      logic inc, dec;
      inc        = a_hs && (grant_idx_q == MIDX_WIDTH'(i));
      dec        = d_hs && (d_idx == MIDX_WIDTH'(i));
      outst_d[i] = outst_q[i];
      if (inc && !dec) begin
        outst_d[i] = outst_q[i] + CntW'(1);
      end else if (dec && !inc && (outst_q[i] != '0)) begin
        outst_d[i] = outst_q[i] - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_100) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      grant_idx_q  <= '0;
      rr_ptr_q     <= '0;
      err_phase_q  <= 1'b0;
      err_opcode_q <= '0;
      err_size_q   <= '0;
      err_source_q <= '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        outst_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      rr_ptr_q     <= rr_ptr_d;
      err_phase_q  <= err_phase_d;
      err_opcode_q <= err_opcode_d;
      err_size_q   <= err_size_d;
      err_source_q <= err_source_d;
      outst_q      <= outst_d;
    end
  end

endmodule

// File: tb/tb_tlul_a_arbiter.sv
// Directed bench for tlul_a_arbiter: grant order, tagging, D routing, outstanding limit, stalls.
module tb_tlul_a_arbiter;
  import tlul_pkg::*;

  logic        clk_100 = 1'b0;
  logic        reset;
  logic [2:0]  master_a_valid, master_a_ready;
  logic [8:0]  master_a_opcode, master_a_param, master_a_size;
  logic [5:0]  master_a_source;
  logic [95:0] master_a_address, master_a_data;
  logic [11:0] master_a_mask;
  logic [2:0]  master_d_valid, master_d_ready;
  logic [8:0]  master_d_opcode, master_d_param, master_d_size;
  logic [5:0]  master_d_source;
  logic [2:0]  master_d_sink, master_d_error;
  logic [95:0] master_d_data;
  logic        slave_a_valid, slave_a_ready;
  logic [2:0]  slave_a_opcode, slave_a_param, slave_a_size;
  logic [3:0]  slave_a_source;
  logic [31:0] slave_a_address, slave_a_data;
  logic [3:0]  slave_a_mask;
  logic        slave_d_valid, slave_d_ready;
  logic [2:0]  slave_d_opcode, slave_d_param, slave_d_size;
  logic [3:0]  slave_d_source;
  logic        slave_d_sink, slave_d_error;
  logic [31:0] slave_d_data;

  int n_tests = 0;
  int n_fail  = 0;
  int hs;
  logic [1:0] kk;

  always #5 clk_100 = ~clk_100;

  tlul_a_arbiter #(
    .SLAVE_BASE (32'h0000_2000)
  ) dut (
    .clk_100          (clk_100),
    .reset            (reset),
    .master_a_valid   (master_a_valid),
    .master_a_ready   (master_a_ready),
    .master_a_opcode  (master_a_opcode),
    .master_a_param   (master_a_param),
    .master_a_size    (master_a_size),
    .master_a_source  (master_a_source),
    .master_a_address (master_a_address),
    .master_a_mask    (master_a_mask),
    .master_a_data    (master_a_data),
    .master_d_valid   (master_d_valid),
    .master_d_ready   (master_d_ready),
    .master_d_opcode  (master_d_opcode),
    .master_d_param   (master_d_param),
    .master_d_size    (master_d_size),
    .master_d_source  (master_d_source),
    .master_d_sink    (master_d_sink),
    .master_d_data    (master_d_data),
    .master_d_error   (master_d_error),
    .slave_a_valid    (slave_a_valid),
    .slave_a_ready    (slave_a_ready),
    .slave_a_opcode   (slave_a_opcode),
    .slave_a_param    (slave_a_param),
    .slave_a_size     (slave_a_size),
    .slave_a_source   (slave_a_source),
    .slave_a_address  (slave_a_address),
    .slave_a_mask     (slave_a_mask),
    .slave_a_data     (slave_a_data),
    .slave_d_valid    (slave_d_valid),
    .slave_d_ready    (slave_d_ready),
    .slave_d_opcode   (slave_d_opcode),
    .slave_d_param    (slave_d_param),
    .slave_d_size     (slave_d_size),
    .slave_d_source   (slave_d_source),
    .slave_d_sink     (slave_d_sink),
    .slave_d_data     (slave_d_data),
    .slave_d_error    (slave_d_error)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    master_a_valid = '0; master_a_opcode = '0; master_a_param = '0; master_a_size = '0;
    master_a_source = '0; master_a_address = '0; master_a_mask = '0; master_a_data = '0;
    master_d_ready = 3'b111;
    slave_a_ready = 1'b1;
    slave_d_valid = 1'b1; slave_d_opcode = '0; slave_d_param = '0; slave_d_size = '0;
    slave_d_source = '0; slave_d_sink = 1'b0; slave_d_data = '0; slave_d_error = 1'b0;

    // Reset state, with a stray D beat present to show outputs are held quiet.
    repeat (2) @(negedge clk_100);
    #1;
    chk("rst_slave_a_valid", 64'(slave_a_valid), 64'd0);
    chk("rst_master_a_ready", 64'(master_a_ready), 64'd0);
    chk("rst_master_d_valid", 64'(master_d_valid), 64'd0);
    chk("rst_slave_d_ready", 64'(slave_d_ready), 64'd0);

    // All three masters request together: granted 0,1,2, two cycles apart.
    @(negedge clk_100);
    reset = 1'b0;
    slave_d_valid = 1'b0;
    master_a_valid = 3'b111;
    for (int i = 0; i < 3; i++) begin
      master_a_opcode[i*3 +: 3]   = PutPartialData;
      master_a_address[i*32 +: 32] = 32'h2000 + 32'(4 * i);
      master_a_data[i*32 +: 32]    = 32'(i + 1);
      master_a_mask[i*4 +: 4]      = 4'hF;
    end
    for (int k = 0; k < 3; k++) begin
      kk = 2'(k);
      @(negedge clk_100);
      #1;
      chk("rr_valid", 64'(slave_a_valid), 64'd1);
      chk("rr_source", 64'(slave_a_source), 64'({kk, 2'b00}));
      chk("rr_ready", 64'(master_a_ready), 64'(3'b001 << k));
      chk("rr_address", 64'(slave_a_address), 64'(32'h2000 + 32'(4 * k)));
      @(negedge clk_100);
      master_a_valid[k] = 1'b0;
      #1;
      chk("rr_idle_gap", 64'(slave_a_valid), 64'd0);
    end

    // Return one response to each master.
    for (int k = 0; k < 3; k++) begin
      kk = 2'(k);
      slave_d_valid  = 1'b1;
      slave_d_source = {kk, 2'b00};
      #1;
      chk("drain_d_valid", 64'(master_d_valid), 64'(3'b001 << k));
      chk("drain_d_ready", 64'(slave_d_ready), 64'd1);
      @(negedge clk_100);
    end
    slave_d_valid = 1'b0;

    // Master 1 Put with source 2'b11, then its response routed back.
    master_a_valid[1]            = 1'b1;
    master_a_opcode[3 +: 3]      = PutFullData;
    master_a_source[2 +: 2]      = 2'b11;
    master_a_address[32 +: 32]   = 32'h2000;
    master_a_data[32 +: 32]      = 32'hCAFE_BABE;
    @(negedge clk_100);
    #1;
    chk("put_valid", 64'(slave_a_valid), 64'd1);
    chk("put_source", 64'(slave_a_source), 64'(4'b0111));
    chk("put_data", 64'(slave_a_data), 64'(32'hCAFE_BABE));
    chk("put_opcode", 64'(slave_a_opcode), 64'(PutFullData));
    @(negedge clk_100);
    master_a_valid[1] = 1'b0;
    slave_d_valid     = 1'b1;
    slave_d_source    = 4'b0111;
    master_d_ready    = 3'b000;
    #1;
    chk("put_d_valid", 64'(master_d_valid), 64'(3'b010));
    chk("put_d_source", 64'(master_d_source[3:2]), 64'(2'b11));
    chk("put_d_backpressure", 64'(slave_d_ready), 64'd0);
    @(negedge clk_100);
    master_d_ready = 3'b111;
    #1;
    chk("put_d_ready", 64'(slave_d_ready), 64'd1);
    @(negedge clk_100);
    slave_d_valid = 1'b0;

    // Master 0 streams Gets with no responses: only MAX_OUTST=4 are accepted.
    master_a_valid[0]          = 1'b1;
    master_a_opcode[0 +: 3]    = Get;
    master_a_source[0 +: 2]    = 2'b00;
    master_a_address[0 +: 32]  = 32'h2010;
    hs = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_100);
      #1;
      if (slave_a_valid && slave_a_ready) hs++;
    end
    chk("outst_beats", 64'(hs), 64'd4);
    chk("outst_fifth_blocked", 64'(slave_a_valid), 64'd0);
    slave_d_valid  = 1'b1;
    slave_d_source = 4'b0000;
    #1;
    chk("outst_d_valid", 64'(master_d_valid), 64'(3'b001));
    @(negedge clk_100);
    slave_d_valid = 1'b0;
    #1;
    chk("outst_no_grant_yet", 64'(slave_a_valid), 64'd0);
    @(negedge clk_100);
    #1;
    chk("outst_fifth_granted", 64'(slave_a_valid), 64'd1);
    chk("outst_fifth_source", 64'(slave_a_source), 64'd0);
    @(negedge clk_100);
    master_a_valid[0] = 1'b0;
    slave_d_valid     = 1'b1;
    repeat (4) @(negedge clk_100);
    slave_d_valid = 1'b0;

    // Master 2 stalled by slave_a_ready=0; master 0 waits behind it.
    slave_a_ready              = 1'b0;
    master_a_valid[2]          = 1'b1;
    master_a_source[4 +: 2]    = 2'b01;
    master_a_address[64 +: 32] = 32'h2020;
    @(negedge clk_100);
    master_a_valid[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("stall_hold", 64'({slave_a_valid, slave_a_source, master_a_ready}),
          64'(8'b1100_1000));
      @(negedge clk_100);
    end
    slave_a_ready = 1'b1;
    #1;
    chk("stall_release_ready", 64'(master_a_ready), 64'(3'b100));
    @(negedge clk_100);
    master_a_valid[2] = 1'b0;
    #1;
    chk("stall_idle_gap", 64'(slave_a_valid), 64'd0);
    @(negedge clk_100);
    #1;
    chk("stall_next_grant", 64'({slave_a_valid, slave_a_source, master_a_ready}),
        64'(8'b1000_0001));
    @(negedge clk_100);
    master_a_valid[0] = 1'b0;

    // Response tagged for a non-existent master is sunk.
    slave_d_valid  = 1'b1;
    slave_d_source = 4'b1100;
    master_d_ready = 3'b000;
    #1;
    chk("badtag_ready", 64'(slave_d_ready), 64'd1);
    chk("badtag_no_valid", 64'(master_d_valid), 64'd0);
    @(negedge clk_100);
    slave_d_valid  = 1'b0;
    master_d_ready = 3'b111;

`ifdef TLUL_ARB_DECERR_EN
    // Out-of-window Get answered locally with an error.
    master_a_valid[0]         = 1'b1;
    master_a_opcode[0 +: 3]   = Get;
    master_a_source[0 +: 2]   = 2'b10;
    master_a_size[0 +: 3]     = 3'd2;
    master_a_address[0 +: 32] = 32'h0000_3000;
    @(negedge clk_100);
    #1;
    chk("decerr_no_fwd", 64'(slave_a_valid), 64'd0);
    chk("decerr_consume", 64'(master_a_ready), 64'(3'b001));
    @(negedge clk_100);
    master_a_valid[0] = 1'b0;
    master_d_ready    = 3'b000;
    slave_d_valid     = 1'b1;
    slave_d_source    = 4'b0001;
    #1;
    chk("decerr_d_valid", 64'(master_d_valid), 64'(3'b001));
    chk("decerr_error", 64'(master_d_error[0]), 64'd1);
    chk("decerr_opcode", 64'(master_d_opcode[2:0]), 64'(AccessAckData));
    chk("decerr_data", 64'(master_d_data[31:0]), 64'd0);
    chk("decerr_source", 64'(master_d_source[1:0]), 64'(2'b10));
    chk("decerr_size", 64'(master_d_size[2:0]), 64'd2);
    chk("decerr_slave_blocked", 64'(slave_d_ready), 64'd0);
    chk("decerr_slave_a_quiet", 64'(slave_a_valid), 64'd0);
    @(negedge clk_100);
    #1;
    chk("decerr_hold", 64'(master_d_valid), 64'(3'b001));
    master_d_ready = 3'b111;
    slave_d_valid  = 1'b0;
    @(negedge clk_100);
    #1;
    chk("decerr_done", 64'(master_d_valid), 64'd0);
`endif

    repeat (2) @(negedge clk_100);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
